rib_sram_slave: RTL and testbench
=================================

// Module: rib_sram_slave
// PURPOSE
//  RIB slave endpoint: single-port word-addressed SRAM attached to one sN_* port of the RIB bus.
//  Bus strips addr[31:28]; this block sees the offset only.
//  Accepts one request per req handshake and returns exactly one response per accepted request
//  (reads and writes). Holds the response until the master takes it.
// PARAMETERS
//  DEPTH    4096  number of 32-bit words (power of 2)
//  AW       12    word-index width, = log2(DEPTH)
//  INIT_EN  0     1: preload memory from INIT_FILE via $readmemh (simulation only)
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  addr_i     in   32  byte offset from bus, [31:28] always 0
//  data_i     in   32  write data
//  sel_i      in   4   byte enables, bit n -> data_i[8n+7:8n]
//  we_i       in   1   1 = write, 0 = read
//  req_vld_i  in   1   request valid
//  req_rdy_o  out  1   request ready
//  rsp_vld_o  out  1   response valid
//  rsp_rdy_i  in   1   master ready for response
//  data_o     out  32  read data (0 for writes)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, rsp_vld_o=0, data_o=0; req_rdy_o=0 while rst=1.
//    Memory contents not reset.
//  Accept: req_fire = req_vld_i & req_rdy_o. addr/data/sel/we sampled at this edge only.
//  Word index = addr_i[AW+1:2]; addr_i[1:0] ignored (no misalignment check).
//  In range: addr_i[27:AW+2]==0. Out of range: write dropped, read returns 32'h0, response still issued.
//  FSM:
//    IDLE -> RSP on req_fire.
//    RSP  -> IDLE on rsp_vld_o & rsp_rdy_i & ~req_fire.
//    RSP  -> RSP  on rsp_vld_o & rsp_rdy_i & req_fire (back-to-back).
//    RSP  -> RSP  otherwise (hold).
//  req_rdy_o = ~rst & (state==IDLE | rsp_rdy_i): combinational on rsp_rdy_i;
//    no combinational path from req_vld_i.
//  Latency: response one cycle after accept. rsp_vld_o=1 in the cycle after req_fire.
//  Throughput: 1 transaction/cycle while rsp_rdy_i=1.
//  Write: on req_fire, mem[idx] byte n <= data_i byte n where sel_i[n]=1.
//    data_o <= 0 at the same edge.
//  Read: on req_fire, data_o <= mem[idx] (sync read, full word, sel_i ignored).
//  Hold: while rsp_vld_o=1 & rsp_rdy_i=0, data_o and rsp_vld_o stay constant and req_rdy_o=0.
//    This holds even if the bus arbiter switches masters.
//  Read after write to the same word, back-to-back: read sees the new data
//    (write in cycle N, read accepted in N+1).
//  Single port: no same-cycle read/write conflict is possible.
//  Response on handshake without a new accept: rsp_vld_o <= 0 next edge; data_o keeps its last value.
//  Reset mid-transaction: pending response is discarded; a write accepted before reset is already committed.
//  req_vld_i deasserted while req_rdy_o=0: legal, nothing is captured.
// STRUCTURE
//  defines include: RIB data width 32, sel width 4, slave-offset width 28 (shared with rib and other slaves).
//  Sub-module sram_sp #(DEPTH,AW): 1 port, clk/en/we/be[3:0]/addr/wdata/rdata,
//    1-cycle read, byte-enabled write. Keep it vendor-swappable.
//  Top: 1-bit FSM, range check, out-of-range mux forcing data_o=0 (flag registered at accept).
// TESTING
//  1 Reset 3 cycles, rst=0 -> req_rdy_o=1, rsp_vld_o=0, data_o=0.
//  2 Write addr 0x10, data 0xDEADBEEF, sel 4'hF, rsp_rdy_i=1 -> rsp_vld_o=1 next cycle, data_o=0.
//    Then read 0x10 -> data_o=0xDEADBEEF one cycle after accept.
//  3 Write 0x10, data 0x000000AA, sel 4'b0001 -> read 0x10 returns 0xDEADBEAA.
//    Read 0x13 returns the same word.
//  4 Read 0x10 with rsp_rdy_i=0 for 5 cycles -> rsp_vld_o=1 and data_o stable, req_rdy_o=0 throughout.
//    rsp_rdy_i=1 -> one handshake, then rsp_vld_o=0.
//  5 Back-to-back: 8 reads at 0x0..0x1C, req_vld_i and rsp_rdy_i held 1 ->
//    8 responses on 8 consecutive cycles, in order, no gaps.
//    Write 0x20 then immediate read 0x20 -> read returns the new value.
//  6 Out of range (DEPTH=4096): write 0x0400_0000 then read it -> both respond, read data 0.
//    mem[0] is unchanged. Assert rst while rsp pending -> rsp_vld_o=0 next edge.

Source files
------------

// File: rtl/rib_sram_slave_pkg.sv
// Shared RIB widths, slave FSM state type and the offset range-check helper.
package rib_sram_slave_pkg;

  localparam int RIB_DW     = 32;
  localparam int RIB_SW     = 4;
  localparam int RIB_OFFS_W = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } state_t;

  // An offset is in range when every bit above the word index is zero.
  function automatic logic offset_in_range(input logic [RIB_DW-1:0] addr, input int aw);
    logic [RIB_OFFS_W-1:0] offs;
    offs = addr[RIB_OFFS_W-1:0];
    return (offs >> (aw + 2)) == '0;
  endfunction

endpackage

// File: rtl/rib_sram_slave_if.sv
// RIB slave-port request/response bundle; signal names follow the bus-side port names.
interface rib_sram_slave_if;
  import rib_sram_slave_pkg::*;

  logic [RIB_DW-1:0] addr_i;
  logic [RIB_DW-1:0] data_i;
  logic [RIB_SW-1:0] sel_i;
  logic              we_i;
  logic              req_vld_i;
  logic              req_rdy_o;
  logic              rsp_vld_o;
  logic              rsp_rdy_i;
  logic [RIB_DW-1:0] data_o;

  modport master (
    output addr_i, data_i, sel_i, we_i, req_vld_i, rsp_rdy_i,
    input  req_rdy_o, rsp_vld_o, data_o
  );

  modport slave (
    input  addr_i, data_i, sel_i, we_i, req_vld_i, rsp_rdy_i,
    output req_rdy_o, rsp_vld_o, data_o
  );
endinterface

// File: rtl/rib_sram_slave_sram_sp.sv
// Single-port word SRAM with byte-enabled writes and one-cycle registered read.
module sram_sp
  import rib_sram_slave_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [RIB_SW-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [RIB_DW-1:0] wdata,
  output logic [RIB_DW-1:0] rdata
);

  // One narrow array per byte lane keeps the byte enables a plain per-lane write enable.
  for (genvar gi = 0; gi < RIB_SW; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) begin
            lane_mem[addr] <= wdata[8*gi +: 8];
          end
        end else begin
          lane_rd_reg <= lane_mem[addr];
        end
      end
    end

    assign rdata[8*gi +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/rib_sram_slave.sv
// RIB slave endpoint: one request accepted per handshake, one held response per request.
module rib_sram_slave
  import rib_sram_slave_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic            clk,
  input  logic            rst,
  rib_sram_slave_if.slave bus
);

  state_t            state_reg;
  logic              rsp_vld_reg;
  logic              zero_data_reg;
  logic              req_rdy;
  logic              req_fire;
  logic              addr_in_range;
  logic [AW-1:0]     word_idx;
  logic [RIB_DW-1:0] sram_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^bus.addr_i[RIB_DW-1:RIB_OFFS_W];

  // A new request can be taken in the same cycle the pending response is consumed.
  assign req_rdy       = ~rst & ((state_reg == ST_IDLE) | bus.rsp_rdy_i);
  assign req_fire      = bus.req_vld_i & req_rdy;
  assign addr_in_range = offset_in_range(bus.addr_i, AW);
  assign word_idx      = bus.addr_i[AW+1:2];

  sram_sp #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (req_fire & addr_in_range),
    .we    (bus.we_i),
    .be    (bus.sel_i),
    .addr  (word_idx),
    .wdata (bus.data_i),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rsp_vld_reg   <= 1'b0;
      zero_data_reg <= 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (req_fire) begin
            state_reg     <= ST_RSP;
            rsp_vld_reg   <= 1'b1;
            zero_data_reg <= bus.we_i | ~addr_in_range;
          end
        end
        ST_RSP: begin
          if (req_fire) begin
            state_reg     <= ST_RSP;
            rsp_vld_reg   <= 1'b1;
            zero_data_reg <= bus.we_i | ~addr_in_range;
          end else if (bus.rsp_rdy_i) begin
            state_reg   <= ST_IDLE;
            rsp_vld_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          rsp_vld_reg <= 1'b0;
        end
      endcase
    end
  end

  // SRAM read register only moves on an accepted in-range read, so data_o holds on its own.
  assign bus.data_o    = zero_data_reg ? '0 : sram_rdata;
  assign bus.rsp_vld_o = rsp_vld_reg;
  assign bus.req_rdy_o = req_rdy;

endmodule

// File: tb/tb_rib_sram_slave.sv
// Directed bench for rib_sram_slave: queued expectations checked by a response monitor.
module tb_rib_sram_slave;
  import rib_sram_slave_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rib_sram_slave_if bus ();

  rib_sram_slave #(
    .DEPTH (4096),
    .AW    (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          cyc = 0;
  logic [31:0] exp_q [$];
  int          rsp_cyc_q [$];
  logic [31:0] mon_exp;

  logic [31:0] wr_tbl [8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                              32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Response monitor: every response handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_vld_o && bus.rsp_rdy_i) begin
      rsp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", bus.data_o, mon_exp);
        $display("rsp cyc=%0d data=%h exp=%h", cyc, bus.data_o, mon_exp);
      end
    end
  end

  // Presents one request and returns just after the edge that accepted it.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic [31:0] e);
    bit fired;
    fired = 1'b0;
    bus.addr_i    = a;
    bus.data_i    = d;
    bus.sel_i     = s;
    bus.we_i      = w;
    bus.req_vld_i = 1'b1;
    for (int i = 0; i < 20 && !fired; i++) begin
      @(negedge clk);
      if (bus.req_rdy_o) begin
        exp_q.push_back(e);
        fired = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (!fired) begin
      chk_cnt++;
      $display("FAIL req_timeout: got no accept for addr %h expected accept", a);
    end
  endtask

  task automatic req_idle();
    bus.req_vld_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr_i    = '0;
    bus.data_i    = '0;
    bus.sel_i     = '0;
    bus.we_i      = 1'b0;
    bus.req_vld_i = 1'b0;
    bus.rsp_rdy_i = 1'b1;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", {31'b0, bus.req_rdy_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req_rdy", {31'b0, bus.req_rdy_o}, 32'd1);
    check("idle_rsp_vld", {31'b0, bus.rsp_vld_o}, 32'd0);
    check("idle_data", bus.data_o, 32'h0);
    @(posedge clk);
    #1;

    // Full-word write then read
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
    check("wr_latency_vld", {31'b0, bus.rsp_vld_o}, 32'd1);
    req_idle();
    do_req(32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    check("rd_latency_vld", {31'b0, bus.rsp_vld_o}, 32'd1);
    req_idle();
    wait_drain();

    // Byte-lane write, misaligned read of the same word
    do_req(32'h10, 32'h000000AA, 4'b0001, 1'b1, 32'h0);
    do_req(32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA);
    do_req(32'h13, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA);
    req_idle();
    wait_drain();

    // Response hold under back-pressure
    bus.rsp_rdy_i = 1'b0;
    do_req(32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA);
    req_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_vld", {31'b0, bus.rsp_vld_o}, 32'd1);
      check("hold_data", bus.data_o, 32'hDEADBEAA);
      check("hold_req_rdy", {31'b0, bus.req_rdy_o}, 32'd0);
    end
    @(posedge clk);
    #1 bus.rsp_rdy_i = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_hs_rsp_vld", {31'b0, bus.rsp_vld_o}, 32'd0);
    check("post_hs_data_kept", bus.data_o, 32'hDEADBEAA);
    check("post_hs_q_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back stream: 8 writes, 8 reads, write+read of 0x20
    rsp_cyc_q.delete();
    for (int i = 0; i < 8; i++) do_req(32'(i * 4), wr_tbl[i], 4'hF, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) do_req(32'(i * 4), 32'h0, 4'hF, 1'b0, wr_tbl[i]);
    do_req(32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0);
    do_req(32'h20, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);
    req_idle();
    wait_drain();
    check("b2b_rsp_count", rsp_cyc_q.size(), 32'd18);
    if (rsp_cyc_q.size() == 18) begin
      for (int i = 1; i < 18; i++)
        check("b2b_no_gap", rsp_cyc_q[i] - rsp_cyc_q[i-1], 32'd1);
    end

    // Out-of-range offset: responds, reads zero, leaves word 0 alone
    do_req(32'h0400_0000, 32'h12345678, 4'hF, 1'b1, 32'h0);
    do_req(32'h0400_0000, 32'h0, 4'hF, 1'b0, 32'h0);
    do_req(32'h0, 32'h0, 4'hF, 1'b0, 32'h11111111);
    req_idle();
    wait_drain();

    // Reset with a response pending discards it
    bus.rsp_rdy_i = 1'b0;
    do_req(32'h4, 32'h0, 4'hF, 1'b0, 32'h22222222);
    req_idle();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_pending_rsp_vld", {31'b0, bus.rsp_vld_o}, 32'd0);
    check("rst_pending_data", bus.data_o, 32'h0);
    check("rst_pending_req_rdy", {31'b0, bus.req_rdy_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_rdy_i = 1'b1;
    @(negedge clk);
    check("after_rst_req_rdy", {31'b0, bus.req_rdy_o}, 32'd1);
    check("after_rst_rsp_vld", {31'b0, bus.rsp_vld_o}, 32'd0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
